// File: rtl/user_led_axil_arbiter.sv
// user_led_axil_arbiter
// Two-port round-robin arbiter and sequencer in front of the user_led
// AXI4-Lite register bank. It grants one requester at a time and runs the
// full AW/W/B or AR/R handshake as master. The response goes back to the
// granted port only. Only one AXI transaction is outstanding at any time.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     : per-port command handshake (ready = 1-cycle accept)
//   req_we, req_addrN,
//   req_wdataN              : per-port command (1 = write), byte address, data
//   rsp_valid               : per-port 1-cycle completion pulse (no backpressure)
//   rsp_rdata, rsp_resp     : read data (0 for writes) and BRESP/RRESP
//   m_axi_*                 : AXI4-Lite master towards the S00_AXI slave
module user_led_axil_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr0,
    input  logic [ADDR_WIDTH-1:0]   req_addr1,
    input  logic [DATA_WIDTH-1:0]   req_wdata0,
    input  logic [DATA_WIDTH-1:0]   req_wdata1,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, DONE} state_t;

    state_t                  state, state_n;
    logic                    grant, grant_n;
    logic                    last_grant, last_grant_n;
    logic                    aw_done, aw_done_n;
    logic                    w_done, w_done_n;
    logic                    awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic [ADDR_WIDTH-1:0]   awaddr_n, araddr_n;
    logic [DATA_WIDTH-1:0]   wdata_n, rsp_rdata_n;
    logic [1:0]              rsp_resp_n, rsp_valid_n;

    logic                    pick;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    aw_hs, w_hs;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = '1;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;

    // On a tie, the port that did not win last time gets the grant.
    always_comb begin
        if (&req_valid) pick = ~last_grant;
        else            pick = req_valid[1];
        sel_addr       = pick ? req_addr1 : req_addr0;
        sel_addr[1:0]  = 2'b00;   // word-aligned register bank
        sel_wdata      = pick ? req_wdata1 : req_wdata0;
    end

    // Accept pulse is combinational so the command is taken in the same cycle
    // it is seen in IDLE; the AXI side stays fully registered.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset && |req_valid) req_ready[pick] = 1'b1;
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        awvalid_n    = m_axi_awvalid;
        wvalid_n     = m_axi_wvalid;
        bready_n     = m_axi_bready;
        arvalid_n    = m_axi_arvalid;
        rready_n     = m_axi_rready;
        awaddr_n     = m_axi_awaddr;
        araddr_n     = m_axi_araddr;
        wdata_n      = m_axi_wdata;
        rsp_rdata_n  = rsp_rdata;
        rsp_resp_n   = rsp_resp;
        rsp_valid_n  = '0;

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_n      = pick;
                    last_grant_n = pick;
                    if (req_we[pick]) begin
                        state_n   = WR;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        awaddr_n  = sel_addr;
                        wdata_n   = sel_wdata;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                    end else begin
                        state_n   = RD_AR;
                        arvalid_n = 1'b1;
                        araddr_n  = sel_addr;
                    end
                end
            end
            WR: begin
                // AW and W complete independently, in any order or together.
                if (aw_hs) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (w_hs) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_n  = WR_B;
                    bready_n = 1'b1;
                end
            end
            WR_B: begin
                if (m_axi_bvalid) begin
                    bready_n           = 1'b0;
                    rsp_resp_n         = m_axi_bresp;
                    rsp_rdata_n        = '0;
                    rsp_valid_n[grant] = 1'b1;
                    state_n            = DONE;
                end
            end
            RD_AR: begin
                if (m_axi_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_R;
                end
            end
            RD_R: begin
                if (m_axi_rvalid) begin
                    rready_n           = 1'b0;
                    rsp_resp_n         = m_axi_rresp;
                    rsp_rdata_n        = m_axi_rdata;
                    rsp_valid_n[grant] = 1'b1;
                    state_n            = DONE;
                end
            end
            DONE: begin
                // rsp_valid is high for this one cycle only.
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;   // port 0 wins the first tie
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            rsp_valid     <= '0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            last_grant    <= last_grant_n;
            aw_done       <= aw_done_n;
            w_done        <= w_done_n;
            m_axi_awvalid <= awvalid_n;
            m_axi_wvalid  <= wvalid_n;
            m_axi_bready  <= bready_n;
            m_axi_arvalid <= arvalid_n;
            m_axi_rready  <= rready_n;
            m_axi_awaddr  <= awaddr_n;
            m_axi_araddr  <= araddr_n;
            m_axi_wdata   <= wdata_n;
            rsp_rdata     <= rsp_rdata_n;
            rsp_resp      <= rsp_resp_n;
            rsp_valid     <= rsp_valid_n;
        end
    end

endmodule

// File: tb/tb_user_led_axil_arbiter.sv
// Testbench for user_led_axil_arbiter: a register-bank slave model, directed
// stimulus per port, and a scoreboard queue checked by an independent monitor.
module tb_user_led_axil_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_we;
    logic [3:0]  req_addr0, req_addr1;
    logic [31:0] req_wdata0, req_wdata1;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 clock = ~clock;

    user_led_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // ---------------- slave model: 4 x 32-bit registers ----------------
    logic [31:0] mem [4];
    logic        aw_got, w_got;
    logic [3:0]  aw_a;
    logic [31:0] w_d;
    logic [1:0]  rresp_cfg;
    logic        aw_hs, w_hs, aw_now, w_now;
    logic [3:0]  a_now;
    logic [31:0] d_now;

    assign m_axi_arready = 1'b1;
    assign aw_hs  = m_axi_awvalid & m_axi_awready;
    assign w_hs   = m_axi_wvalid & m_axi_wready;
    assign aw_now = aw_got | aw_hs;
    assign w_now  = w_got | w_hs;
    assign a_now  = aw_got ? aw_a : m_axi_awaddr;
    assign d_now  = w_got ? w_d : m_axi_wdata;

    always @(posedge clock) begin
        if (reset) begin
            aw_got <= 1'b0; w_got <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
            m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
        end else begin
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if (aw_now && w_now) begin
                mem[a_now[3:2]] <= d_now;
                aw_got <= 1'b0; w_got <= 1'b0;
                m_axi_bvalid <= 1'b1; m_axi_bresp <= 2'b00;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_a <= m_axi_awaddr; end
                if (w_hs)  begin w_got <= 1'b1; w_d <= m_axi_wdata; end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= mem[m_axi_araddr[3:2]];
                m_axi_rresp  <= rresp_cfg;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sbq[$];
    int   glog[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ready_viol = 0;
    int   align_viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clock) begin
        if (req_ready == 2'b11) ready_viol++;
        else if (req_ready != 2'b00) glog.push_back(int'(req_ready[1]));
        if ((m_axi_awvalid && m_axi_awaddr[1:0] != 2'b00) ||
            (m_axi_arvalid && m_axi_araddr[1:0] != 2'b00)) align_viol++;
        if (rsp_valid != 2'b00) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_port",  {30'd0, rsp_valid}, (e.port == 0) ? 32'd1 : 32'd2);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp",  {30'd0, rsp_resp}, {30'd0, e.resp});
            end
        end
    end

    // Raise a command on port p, wait for its accept pulse, then drop it.
    task automatic issue(input int p, input bit we, input logic [3:0] a, input logic [31:0] d,
                         input bit exp_rsp, input logic [31:0] er, input logic [1:0] eresp);
        int   n;
        exp_t e;
        @(posedge clock); #1;
        req_we[p] = we;
        if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
        else        begin req_addr1 = a; req_wdata1 = d; end
        req_valid[p] = 1'b1;
        @(negedge clock);
        n = 0;
        while (!req_ready[p] && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready[p]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid[p] = 1'b0;
            return;
        end
        if (exp_rsp) begin
            e.port = p; e.rdata = er; e.resp = eresp;
            sbq.push_back(e);
        end
        @(posedge clock); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("drain", sbq.size(), 32'd0);
        repeat (2) @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        reset = 1'b1;
        req_valid = '0; req_we = '0;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; rresp_cfg = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        // reset state
        chk("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                           m_axi_arvalid, m_axi_rready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_data", rsp_rdata, 32'd0);
        chk("rst_addr", {24'd0, m_axi_awaddr, m_axi_araddr}, 32'd0);
        chk("rst_wdata", m_axi_wdata, 32'd0);
        reset = 1'b0;

        // 1: port 0 write, zero-wait slave latency
        issue(0, 1'b1, 4'h0, 32'h1, 1'b1, 32'h0, 2'b00);          // now T+1
        chk("t1_awvalid", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
        chk("t1_awaddr", {28'd0, m_axi_awaddr}, 32'h0);
        chk("t1_wdata", m_axi_wdata, 32'h1);
        chk("t1_wstrb", {28'd0, m_axi_wstrb}, 32'hF);
        @(posedge clock); #1;                                      // T+2
        chk("t2_valids_low", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd0);
        chk("t2_bready", {31'd0, m_axi_bready}, 32'd1);
        @(posedge clock); #1;                                      // T+3
        chk("t3_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        drain();

        // 2: port 1 fills the bank, then reads it back
        for (int i = 0; i < 4; i++)
            issue(1, 1'b1, 4'(i * 4), 32'(i + 1), 1'b1, 32'h0, 2'b00);
        for (int i = 0; i < 4; i++)
            issue(1, 1'b0, 4'(i * 4), 32'h0, 1'b1, 32'(i + 1), 2'b00);
        drain();

        // 3: both ports contend; port 1 uses unaligned addresses
        glog.delete();
        fork
            begin
                issue(0, 1'b1, 4'h0, 32'h10, 1'b1, 32'h0, 2'b00);
                issue(0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h10, 2'b00);
            end
            begin
                issue(1, 1'b1, 4'h6, 32'h20, 1'b1, 32'h0, 2'b00);
                issue(1, 1'b0, 4'h5, 32'h0, 1'b1, 32'h20, 2'b00);
            end
        join
        drain();
        exp_order = '{0, 1, 0, 1};
        chk("grant_count", glog.size(), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk("grant_order", glog[i], exp_order[i]);

        // 4: awready immediate, wready only at T+4
        m_axi_wready = 1'b0;
        issue(0, 1'b1, 4'hC, 32'h55, 1'b1, 32'h0, 2'b00);         // T+1
        chk("w_t1", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
        @(posedge clock); #1;                                      // T+2
        chk("w_t2", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'b010);
        @(posedge clock); #1;                                      // T+3
        chk("w_t3", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'b010);
        @(posedge clock); #1;                                      // T+4
        chk("w_t4", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'b010);
        m_axi_wready = 1'b1;
        @(posedge clock); #1;                                      // T+5
        chk("w_t5", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'b001);
        @(posedge clock); #1;                                      // T+6
        chk("w_t6_bready", {31'd0, m_axi_bready}, 32'd0);
        chk("w_t6_rsp", {30'd0, rsp_valid}, 32'd1);
        drain();

        // 5: error response with data is passed through
        issue(1, 1'b1, 4'h8, 32'hDEADBEEF, 1'b1, 32'h0, 2'b00);
        drain();
        rresp_cfg = 2'b10;
        issue(1, 1'b0, 4'h8, 32'h0, 1'b1, 32'hDEADBEEF, 2'b10);
        drain();
        rresp_cfg = 2'b00;

        // 6: reset during WR_B of a port 0 write
        issue(0, 1'b1, 4'h0, 32'h99, 1'b0, 32'h0, 2'b00);         // T+1
        @(posedge clock); #1;                                      // T+2, WR_B
        chk("r_in_wrb", {31'd0, m_axi_bready}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("r_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                         m_axi_arvalid, m_axi_rready}, 32'd0);
        chk("r_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clock);
        glog.delete();
        fork
            issue(0, 1'b0, 4'h4, 32'h0, 1'b1, 32'h20, 2'b00);
            issue(1, 1'b0, 4'h8, 32'h0, 1'b1, 32'hDEADBEEF, 2'b00);
        join
        drain();
        chk("r_tie_count", glog.size(), 32'd2);
        if (glog.size() > 0) chk("r_tie_first", glog[0], 32'd0);

        chk("ready_onehot", ready_viol, 32'd0);
        chk("addr_aligned", align_viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/user_led_axil_arbiter.md
# user_led_axil_arbiter

Two-port round-robin arbiter and sequencer that shares the single AXI4-Lite slave register bank of the user_led IP between two on-chip requesters (e.g. the FOBOS control FSM and a debug port). Each requester issues simple single-word read/write commands. The block grants one at a time, runs the full AXI4-Lite AW/W/B or AR/R handshake as master, and returns the response to the granted requester only. It sits between the requesters and the user_led S00_AXI port; only one AXI transaction is outstanding at any time.

## Interface
Parameters:
- ADDR_WIDTH, 4, byte-address width of the register bank (4 × 32-bit registers).
- DATA_WIDTH, 32, data width; fixed at 32 (AXI4-Lite).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid[1:0]  in  2  per-port command request; held until req_ready.
- req_ready[1:0]  out  2  one-cycle accept pulse to the granted port.
- req_we[1:0]  in  2  per-port 1 = write, 0 = read.
- req_addr0, req_addr1  in  ADDR_WIDTH  per-port byte address.
- req_wdata0, req_wdata1  in  32  per-port write data.
- rsp_valid[1:0]  out  2  one-cycle completion pulse to the granted port; no backpressure.
- rsp_rdata  out  32  read data; valid with rsp_valid; 0 for writes.
- rsp_resp  out  2  AXI BRESP/RRESP of the completed transaction.
- m_axi_awaddr  out  ADDR_WIDTH; m_axi_awprot  out  3 (always 0); m_axi_awvalid  out  1; m_axi_awready  in  1.
- m_axi_wdata  out  32; m_axi_wstrb  out  4 (always 4'hF); m_axi_wvalid  out  1; m_axi_wready  in  1.
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
- m_axi_araddr  out  ADDR_WIDTH; m_axi_arprot  out  3 (always 0); m_axi_arvalid  out  1; m_axi_arready  in  1.
- m_axi_rdata  in  32; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1.

## Operation
- States: IDLE, WR (AW+W issue), WR_B, RD_AR, RD_R, DONE.
- IDLE: if any req_valid, grant = the requesting port. If both request, grant = the port not granted last (last_grant). Pulse req_ready[grant]; capture we, addr (low 2 bits forced to 0), wdata; update last_grant. Go to WR or RD_AR.
- WR: awvalid and wvalid asserted together. Each deasserts independently on its own handshake (aw_done/w_done flags). Go to WR_B when both are done, including the same-cycle case.
- WR_B: bready = 1. On bvalid, capture bresp, set rdata = 0, and go to DONE.
- RD_AR: arvalid = 1 until arready, then go to RD_R.
- RD_R: rready = 1. On rvalid, capture rdata/rresp and go to DONE.
- DONE: rsp_valid[grant] = 1 for exactly one cycle, then go to IDLE.
- Request-side changes while a transaction is in flight are ignored. The non-granted port keeps waiting; nothing is dropped or queued.
- No timeout: the block waits indefinitely on a stalled slave.

## Timing
- Reset values:
  - Control outputs: req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready = 0.
  - Data outputs: rsp_rdata = 0, rsp_resp = 0, awaddr/araddr = 0, wdata = 0.
  - Internal: state = IDLE, last_grant = 1, so port 0 wins the first tie.
- Accept cycle T: req_ready pulse. AXI valids rise at T+1, registered.
- Write with zero-wait slave: AW/W handshake at T+1, bvalid at T+2, rsp_valid at T+3. Read is the same: AR at T+1, rvalid T+2, rsp_valid T+3.
- Back-to-back: IDLE is re-entered the cycle after DONE. The earliest next accept is rsp_valid cycle + 1, so there are 4 cycles minimum per transaction.
- All AXI outputs are registered. Valids never depend combinationally on ready.
- Reset asserted mid-transaction returns everything to reset values on the next edge. The in-flight command is lost and no rsp_valid is issued.

## Test plan
- Write port 0 to addr 0x0 with data 0x00000001 against a zero-wait slave:
  - awaddr 0x0, wdata 0x1 and wstrb 0xF at T+1;
  - rsp_valid[0] at T+3 with rsp_resp 0;
  - rsp_valid[1] stays 0.
- Port 1 writes 0x1..0x4 to addrs 0x0, 0x4, 0x8, 0xC, then reads them back -> rsp_rdata 0x1, 0x2, 0x3, 0x4 in order, all resp 0.
- Both ports hold req_valid for 4 transactions:
  - grant order is 0, 1, 0, 1;
  - req_ready never goes high for both ports in the same cycle.
- Slave asserts awready at T+1 but wready only at T+4:
  - awvalid is 0 from T+2;
  - wvalid is held high through T+4;
  - bready is high only in WR_B.
- Slave returns RRESP = 2'b10 with rdata 0xDEADBEEF -> rsp_resp 2'b10 and rsp_rdata 0xDEADBEEF are returned to the requester.
- Reset asserted in WR_B -> all valids are 0 on the next edge, no rsp_valid pulse, and the next tie is granted to port 0.
